// File: rtl/vcr_ovc_state_ctrl_pkg.sv
// Purpose : shared types for the output-VC state controller (OVC state encoding, credit width helper).
// Latency : n/a (types and constant functions only).
// Backpressure: n/a.
// Contents: ovc_state_e, credit_width().
package vcr_ovc_state_ctrl_pkg;

  // Per-OVC allocation state.
  //   IDLE   : free, offered to the VC allocator
  //   ACTIVE : owned by a packet, flits may leave on it
  //   DRAIN  : tail sent, waiting for the downstream buffer to empty
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } ovc_state_e;

  // Credit counters must represent 0..buffer_size inclusive.
  function automatic int credit_width(input int buffer_size);
    return $clog2(buffer_size + 1);
  endfunction

endpackage

// File: rtl/vcr_ovc_state_ctrl_if.sv
// Purpose : bundle of allocator grant, outgoing flit, returning credit and status signals of one output port.
// Latency : n/a (wires only).
// Backpressure: none; credits returned by the downstream router are the only flow control.
// Ports   : master = allocator/crossbar side (drives events, reads status), slave = state controller.
interface vcr_ovc_state_ctrl_if #(
  parameter int num_vcs = 4
);
  logic [num_vcs-1:0] gnt_ovc;
  logic               flit_valid;
  logic               flit_head;
  logic               flit_tail;
  logic [num_vcs-1:0] flit_sel_ovc;
  logic               cred_valid;
  logic [num_vcs-1:0] cred_sel_ovc;
  logic [num_vcs-1:0] elig_ovc;
  logic [num_vcs-1:0] cred_avail_ovc;
  logic               error;

  modport master (
    output gnt_ovc, flit_valid, flit_head, flit_tail, flit_sel_ovc,
    output cred_valid, cred_sel_ovc,
    input  elig_ovc, cred_avail_ovc, error
  );

  modport slave (
    input  gnt_ovc, flit_valid, flit_head, flit_tail, flit_sel_ovc,
    input  cred_valid, cred_sel_ovc,
    output elig_ovc, cred_avail_ovc, error
  );

endinterface

// File: rtl/vcr_ovc_state_ctrl_tracker.sv
// Purpose : state machine plus downstream credit counter for a single output VC.
// Latency : 1 cycle from grant/flit/credit to elig/cred_avail (both decoded from registers).
// Backpressure: none; illegal events are dropped and flagged on err for one cycle.
// Ports   : clk, reset (sync, active high); gnt, flit_vld/flit_head/flit_tail, cred_vld (already
//           decoded to this OVC); elig, cred_avail (registered status); err (combinational violation pulse).
module vcr_ovc_tracker
  import vcr_ovc_state_ctrl_pkg::*;
#(
  parameter int buffer_size          = 8,
  parameter int atomic_vc_allocation = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic gnt,
  input  logic flit_vld,
  input  logic flit_head,
  input  logic flit_tail,
  input  logic cred_vld,
  output logic elig,
  output logic cred_avail,
  output logic err
);

  localparam int            cw   = credit_width(buffer_size);
  localparam logic [cw-1:0] full = cw'(buffer_size);

  ovc_state_e    state, state_nxt;
  logic [cw-1:0] count, count_nxt;
  // Set once a body flit of the current packet has gone out; a head flit after
  // that point means the upstream lost track of packet boundaries.
  logic          body_seen, body_seen_nxt;

  logic gnt_bad;
  logic flit_bad;
  logic flit_legal;
  logic under;
  logic over;
  logic flit_acc;
  logic cred_acc;

  // State register (with counter and packet-boundary flag).
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= full;
      body_seen <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      body_seen <= body_seen_nxt;
    end
  end

  // Violation checks and credit arithmetic. An illegal flit is dropped entirely
  // (no count change, no state change); a legal flit and a credit in the same
  // cycle cancel, so neither can under/overflow in that case.
  always_comb begin
    gnt_bad    = gnt && (state != IDLE);
    flit_bad   = flit_vld && ((state != ACTIVE) || (flit_head && body_seen));
    flit_legal = flit_vld && !flit_bad;
    under      = flit_legal && !cred_vld && (count == '0);
    over       = cred_vld && !flit_legal && (count == full);
    flit_acc   = flit_legal && !under;
    cred_acc   = cred_vld && !over;

    count_nxt = count;
    if (flit_acc && !cred_acc) begin
      count_nxt = count - cw'(1);
    end else if (cred_acc && !flit_acc) begin
      count_nxt = count + cw'(1);
    end
  end

  // Next-state logic. Draining completes on the post-update count, so the OVC
  // is IDLE in the cycle right after the last credit arrives, and a tail that
  // coincides with a credit filling the buffer skips DRAIN altogether.
  always_comb begin
    state_nxt     = state;
    body_seen_nxt = body_seen;
    unique case (state)
      IDLE: begin
        if (gnt) begin
          state_nxt     = ACTIVE;
          body_seen_nxt = 1'b0;
        end
      end
      ACTIVE: begin
        if (flit_acc) begin
          if (flit_tail) begin
            body_seen_nxt = 1'b0;
            if ((atomic_vc_allocation == 0) || (count_nxt == full)) begin
              state_nxt = IDLE;
            end else begin
              state_nxt = DRAIN;
            end
          end else if (!flit_head) begin
            body_seen_nxt = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (count_nxt == full) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt     = IDLE;
        body_seen_nxt = 1'b0;
      end
    endcase
  end

  // Outputs: status decoded straight from registers; err is a one-cycle pulse.
  always_comb begin
    elig       = (state == IDLE);
    cred_avail = (count != '0);
    err        = gnt_bad || flit_bad || under || over;
  end

endmodule

// File: rtl/vcr_ovc_state_ctrl.sv
// Purpose : output-VC state controller for one router output port; one instance per port, whose
//           elig_ovc slices concatenate into the allocator's elig_op_ovc.
// Latency : 1 cycle from any event to elig_ovc / cred_avail_ovc / error.
// Backpressure: none; protocol violations are dropped and latched on a sticky error until reset.
// Ports   : clk, reset (sync, active high); ovc (slave modport: gnt_ovc, flit_*, cred_*, elig_ovc,
//           cred_avail_ovc, error). The interface num_vcs must equal the product of the class params.
module vcr_ovc_state_ctrl
  import vcr_ovc_state_ctrl_pkg::*;
#(
  parameter int num_message_classes  = 2,
  parameter int num_resource_classes = 2,
  parameter int num_vcs_per_class    = 1,
  parameter int buffer_size          = 8,
  parameter int atomic_vc_allocation = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  vcr_ovc_state_ctrl_if.slave  ovc
);

  localparam int num_vcs = num_message_classes * num_resource_classes * num_vcs_per_class;

  logic               flit_sel_ok;
  logic               cred_sel_ok;
  logic               sel_err;
  logic [num_vcs-1:0] trk_err;
  logic [num_vcs-1:0] elig;
  logic [num_vcs-1:0] cred_avail;
  logic               error_q;

  // A select that is zero or has several bits set names no single OVC; the
  // whole event is ignored rather than applied to a guessed VC.
  always_comb begin
    flit_sel_ok = (ovc.flit_sel_ovc != '0) &&
                  ((ovc.flit_sel_ovc & (ovc.flit_sel_ovc - 1'b1)) == '0);
    cred_sel_ok = (ovc.cred_sel_ovc != '0) &&
                  ((ovc.cred_sel_ovc & (ovc.cred_sel_ovc - 1'b1)) == '0);
    sel_err     = (ovc.flit_valid && !flit_sel_ok) || (ovc.cred_valid && !cred_sel_ok);
  end

  for (genvar i = 0; i < num_vcs; i++) begin : gen_ovc
    vcr_ovc_tracker #(
      .buffer_size          (buffer_size),
      .atomic_vc_allocation (atomic_vc_allocation)
    ) u_trk (
      .clk        (clk),
      .reset      (reset),
      .gnt        (ovc.gnt_ovc[i]),
      .flit_vld   (ovc.flit_valid && flit_sel_ok && ovc.flit_sel_ovc[i]),
      .flit_head  (ovc.flit_head),
      .flit_tail  (ovc.flit_tail),
      .cred_vld   (ovc.cred_valid && cred_sel_ok && ovc.cred_sel_ovc[i]),
      .elig       (elig[i]),
      .cred_avail (cred_avail[i]),
      .err        (trk_err[i])
    );
  end

  // Sticky error: any violation on any OVC latches until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      error_q <= 1'b0;
    end else if (sel_err || (|trk_err)) begin
      error_q <= 1'b1;
    end
  end

  assign ovc.elig_ovc       = elig;
  assign ovc.cred_avail_ovc = cred_avail;
  assign ovc.error          = error_q;

endmodule

// File: tb/tb_vcr_ovc_state_ctrl.sv
module tb_vcr_ovc_state_ctrl;

  logic clk;
  logic reset;

  vcr_ovc_state_ctrl_if #(.num_vcs(4)) bus ();

  vcr_ovc_state_ctrl #(
    .num_message_classes  (2),
    .num_resource_classes (2),
    .num_vcs_per_class    (1),
    .buffer_size          (4),
    .atomic_vc_allocation (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ovc   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic       r;
    logic [3:0] g;
    logic       fv;
    logic       fh;
    logic       ft;
    logic [3:0] fs;
    logic       cv;
    logic [3:0] cs;
    logic [3:0] ee;
    logic [3:0] ec;
    logic       er;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input string nm, input logic r, input logic [3:0] g,
                              input logic fv, input logic fh, input logic ft, input logic [3:0] fs,
                              input logic cv, input logic [3:0] cs,
                              input logic [3:0] ee, input logic [3:0] ec, input logic er);
    vec_t v;
    v.nm = nm; v.r = r; v.g = g; v.fv = fv; v.fh = fh; v.ft = ft; v.fs = fs;
    v.cv = cv; v.cs = cs; v.ee = ee; v.ec = ec; v.er = er;
    return v;
  endfunction

  // Apply one cycle of inputs at the falling edge; the rising edge in between
  // consumes them, and outputs are sampled at the following falling edge.
  task automatic drive(input logic r, input logic [3:0] g, input logic fv, input logic fh,
                       input logic ft, input logic [3:0] fs, input logic cv, input logic [3:0] cs);
    reset            = r;
    bus.gnt_ovc      = g;
    bus.flit_valid   = fv;
    bus.flit_head    = fh;
    bus.flit_tail    = ft;
    bus.flit_sel_ovc = fs;
    bus.cred_valid   = cv;
    bus.cred_sel_ovc = cs;
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [3:0] ee, input logic [3:0] ec, input logic er);
    n_tests++;
    if (bus.elig_ovc !== ee || bus.cred_avail_ovc !== ec || bus.error !== er) begin
      n_fail++;
      $display("FAIL %s: got elig=%b cav=%b err=%b, expected elig=%b cav=%b err=%b",
               nm, bus.elig_ovc, bus.cred_avail_ovc, bus.error, ee, ec, er);
    end
  endtask

  task automatic do_reset(input string nm);
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000);
    chk(nm, 4'b1111, 4'b1111, 1'b0);
  endtask

  initial begin
    // Continuous scenario; state carries from row to row.
    //               name            rst  gnt      fv   fh   ft   fsel     cv   csel     elig     cav      err
    vecs.push_back(mk("reset",        1, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b1111, 4'b1111, 0));
    vecs.push_back(mk("rst_override", 1, 4'b0100, 1, 1, 1, 4'b0100, 1, 4'b0001, 4'b1111, 4'b1111, 0));
    vecs.push_back(mk("gnt2",         0, 4'b0100, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b1011, 4'b1111, 0));
    vecs.push_back(mk("gnt2_hold",    0, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b1011, 4'b1111, 0));
    vecs.push_back(mk("ht_flit2",     0, 4'b0000, 1, 1, 1, 4'b0100, 0, 4'b0000, 4'b1011, 4'b1111, 0));
    vecs.push_back(mk("drain2_a",     0, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b1011, 4'b1111, 0));
    vecs.push_back(mk("drain2_b",     0, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b1011, 4'b1111, 0));
    vecs.push_back(mk("cred2_free",   0, 4'b0000, 0, 0, 0, 4'b0000, 1, 4'b0100, 4'b1111, 4'b1111, 0));
    vecs.push_back(mk("gnt1",         0, 4'b0010, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b1101, 4'b1111, 0));
    vecs.push_back(mk("head1",        0, 4'b0000, 1, 1, 0, 4'b0010, 0, 4'b0000, 4'b1101, 4'b1111, 0));
    vecs.push_back(mk("body1",        0, 4'b0000, 1, 0, 0, 4'b0010, 0, 4'b0000, 4'b1101, 4'b1111, 0));
    vecs.push_back(mk("flit_cred1",   0, 4'b0000, 1, 0, 0, 4'b0010, 1, 4'b0010, 4'b1101, 4'b1111, 0));
    vecs.push_back(mk("body1_b",      0, 4'b0000, 1, 0, 0, 4'b0010, 0, 4'b0000, 4'b1101, 4'b1111, 0));
    vecs.push_back(mk("tail1_cnt0",   0, 4'b0000, 1, 0, 1, 4'b0010, 0, 4'b0000, 4'b1101, 4'b1101, 0));
    vecs.push_back(mk("gnt0",         0, 4'b0001, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b1100, 4'b1101, 0));
    vecs.push_back(mk("flit0_1",      0, 4'b0000, 1, 1, 0, 4'b0001, 0, 4'b0000, 4'b1100, 4'b1101, 0));
    vecs.push_back(mk("flit0_2",      0, 4'b0000, 1, 0, 0, 4'b0001, 0, 4'b0000, 4'b1100, 4'b1101, 0));
    vecs.push_back(mk("flit0_3",      0, 4'b0000, 1, 0, 0, 4'b0001, 0, 4'b0000, 4'b1100, 4'b1101, 0));
    vecs.push_back(mk("flit0_4",      0, 4'b0000, 1, 0, 0, 4'b0001, 0, 4'b0000, 4'b1100, 4'b1100, 0));
    vecs.push_back(mk("flit0_under",  0, 4'b0000, 1, 0, 0, 4'b0001, 0, 4'b0000, 4'b1100, 4'b1100, 1));
    vecs.push_back(mk("cred0_after",  0, 4'b0000, 0, 0, 0, 4'b0000, 1, 4'b0001, 4'b1100, 4'b1101, 1));
    vecs.push_back(mk("cred1_drain",  0, 4'b0000, 0, 0, 0, 4'b0000, 1, 4'b0010, 4'b1100, 4'b1111, 1));
    vecs.push_back(mk("rst_in_drain", 1, 4'b1000, 0, 0, 0, 4'b0000, 1, 4'b0010, 4'b1111, 4'b1111, 0));
    vecs.push_back(mk("gnt3",         0, 4'b1000, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0111, 4'b1111, 0));
    vecs.push_back(mk("gnt3_again",   0, 4'b1000, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0111, 4'b1111, 1));
    vecs.push_back(mk("err_sticky",   0, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0111, 4'b1111, 1));
    vecs.push_back(mk("head3",        0, 4'b0000, 1, 1, 0, 4'b1000, 0, 4'b0000, 4'b0111, 4'b1111, 1));
    vecs.push_back(mk("body3_a",      0, 4'b0000, 1, 0, 0, 4'b1000, 0, 4'b0000, 4'b0111, 4'b1111, 1));
    vecs.push_back(mk("body3_b",      0, 4'b0000, 1, 0, 0, 4'b1000, 0, 4'b0000, 4'b0111, 4'b1111, 1));
    vecs.push_back(mk("tail3_cnt0",   0, 4'b0000, 1, 0, 1, 4'b1000, 0, 4'b0000, 4'b0111, 4'b0111, 1));
    vecs.push_back(mk("cred3_1",      0, 4'b0000, 0, 0, 0, 4'b0000, 1, 4'b1000, 4'b0111, 4'b1111, 1));

    reset = 1'b1;
    bus.gnt_ovc = '0; bus.flit_valid = 1'b0; bus.flit_head = 1'b0; bus.flit_tail = 1'b0;
    bus.flit_sel_ovc = '0; bus.cred_valid = 1'b0; bus.cred_sel_ovc = '0;
    @(negedge clk);

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].g, vecs[i].fv, vecs[i].fh, vecs[i].ft, vecs[i].fs,
            vecs[i].cv, vecs[i].cs);
      chk(vecs[i].nm, vecs[i].ee, vecs[i].ec, vecs[i].er);
    end

    // OVC3 drains back to four credits; error must stay latched throughout.
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b1000);
    chk("cred3_2", 4'b0111, 4'b1111, 1'b1);
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b1000);
    chk("cred3_3", 4'b0111, 4'b1111, 1'b1);
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b1000);
    chk("cred3_free", 4'b1111, 4'b1111, 1'b1);

    // Flit on an IDLE OVC is rejected and does not consume a credit.
    do_reset("rst_b");
    drive(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b0001, 1'b0, 4'b0000);
    chk("flit_idle", 4'b1111, 4'b1111, 1'b1);

    // Credit into a full buffer is an overflow.
    do_reset("rst_c");
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0100);
    chk("cred_over", 4'b1111, 4'b1111, 1'b1);

    // Non-one-hot flit select is ignored and flagged.
    do_reset("rst_d");
    drive(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000);
    chk("gnt0_d", 4'b1110, 4'b1111, 1'b0);
    drive(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b0011, 1'b0, 4'b0000);
    chk("flit_multi", 4'b1110, 4'b1111, 1'b1);

    // Zero credit select with valid high is flagged.
    do_reset("rst_e");
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000);
    chk("cred_nosel", 4'b1111, 4'b1111, 1'b1);

    // Head flit after a body flit on the same ACTIVE OVC.
    do_reset("rst_f");
    drive(1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000);
    drive(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0010, 1'b0, 4'b0000);
    drive(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 4'b0000);
    chk("body_ok", 4'b1101, 4'b1111, 1'b0);
    drive(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0010, 1'b0, 4'b0000);
    chk("head_after_body", 4'b1101, 4'b1111, 1'b1);

    drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vcr_ovc_state_ctrl.md
VCR_OVC_STATE_CTRL -- requirements
Module: vcr_ovc_state_ctrl

Interface
REQ-001 SHALL have parameter num_message_classes, default 2, message classes.
REQ-002 SHALL have parameter num_resource_classes, default 2, resource classes.
REQ-003 SHALL have parameter num_vcs_per_class, default 1, VCs per packet class; num_vcs = num_message_classes*num_resource_classes*num_vcs_per_class.
REQ-004 SHALL have parameter buffer_size, default 8, downstream flit slots (credits) per output VC.
REQ-005 SHALL have parameter atomic_vc_allocation, default 1, 1 = OVC re-eligible only after downstream buffer fully drains.
REQ-006 SHALL have ports: clk input 1, the clock; reset input 1, synchronous active-high reset.
REQ-007 SHALL have ports: gnt_ovc input num_vcs, OVCs of this output port granted by the VC allocator this cycle (any subset).
REQ-008 SHALL have ports: flit_valid input 1, flit_head input 1, flit_tail input 1, flit_sel_ovc input num_vcs (one-hot), flit leaving on this port.
REQ-009 SHALL have ports: cred_valid input 1, cred_sel_ovc input num_vcs (one-hot), credit returned from downstream.
REQ-010 SHALL have ports: elig_ovc output num_vcs, OVC free for allocation; drives this port's slice of the allocator's elig_op_ovc.
REQ-011 SHALL have ports: cred_avail_ovc output num_vcs, OVC holds at least one credit; error output 1, sticky protocol violation.

Function
REQ-012 SHALL keep, per OVC, a state in {IDLE, ACTIVE, DRAIN} and a credit count of width clog2(buffer_size+1).
REQ-013 SHALL move IDLE->ACTIVE on gnt_ovc bit set; elig_ovc bit drops in the next cycle (1-cycle registered latency).
REQ-014 SHALL move ACTIVE->DRAIN on a valid tail flit for that OVC when atomic_vc_allocation=1, ACTIVE->IDLE when 0.
REQ-015 SHALL move DRAIN->IDLE in the cycle after the credit count reaches buffer_size; credit return and tail in same cycle evaluated on the post-update count.
REQ-016 SHALL count credits: flit only -> -1; credit only -> +1; both on same OVC same cycle -> unchanged.
REQ-017 SHALL drive elig_ovc = (state==IDLE) and cred_avail_ovc = (count!=0), both from registers, no combinational input path.
REQ-018 SHALL treat a head+tail flit (single-flit packet) as a tail for state transitions.
REQ-019 SHALL set error and leave state unchanged on: gnt to non-IDLE OVC; flit to OVC not ACTIVE; head flit on ACTIVE OVC after a body flit.
REQ-020 SHALL set error and hold the counter on: flit with count 0 (no underflow); credit with count buffer_size (no overflow).
REQ-021 SHALL set error on a non-one-hot flit_sel_ovc or cred_sel_ovc while its valid is high, ignoring that event.
REQ-022 SHALL keep error asserted until reset.

Reset
REQ-023 SHALL, on reset high at a clock edge, force all OVCs IDLE, counts to buffer_size, elig_ovc all ones, cred_avail_ovc all ones, error 0, overriding same-cycle events.
REQ-024 SHALL discard in-flight packets on reset mid-operation; no event in the reset cycle affects post-reset state.

Structure
REQ-025 SHALL place the state encoding (IDLE, ACTIVE, DRAIN) and credit-width function in the shared vcr package.
REQ-026 SHALL implement per-OVC FSM plus counter as sub-module vcr_ovc_tracker, instantiated num_vcs times; top handles one-hot checks and error OR.
REQ-027 SHALL be instantiated once per output port; num_ports instances concatenate into elig_op_ovc.

Verification (num_vcs=4, buffer_size=4, atomic=1)
REQ-028 SHALL check reset: elig_ovc=4'b1111, cred_avail_ovc=4'b1111, error=0.
REQ-029 SHALL check gnt_ovc=4'b0100 at t -> elig_ovc=4'b1011 at t+1; head+tail flit on OVC2 at t+2 -> DRAIN, count 3, elig stays low; credit at t+5 -> elig_ovc=4'b1111 at t+6.
REQ-030 SHALL check four flits on OVC0 without credits -> cred_avail_ovc[0]=0; fifth flit -> error=1, count held 0.
REQ-031 SHALL check simultaneous flit and credit on OVC1 at count 2 -> count remains 2, no error.
REQ-032 SHALL check gnt on ACTIVE OVC3 -> error=1, state ACTIVE; error persists until reset.
REQ-033 SHALL check reset asserted in DRAIN with count 1 -> all OVCs IDLE, counts 4, error 0 next cycle.
